// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier: one shared N-bit ripple-carry adder,
// N CALC cycles per operation, one-cycle done pulse, held product.
module seq_mult_ctrl #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic [N-1:0]   mcand_r;
  logic [2*N-1:0] acc_r;
  logic [2*N-1:0] acc_next_s;
  logic [CW-1:0]  step_r;
  logic           last_step_s;
  logic [N-1:0]   addend_s;
  logic [N-1:0]   sum_s;
  logic           carry_s;

  // Full-adder chain with carry-in tied low; returns {carry_out, sum}.
  function automatic logic [N:0] rca_add(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0]   c;
    logic [N-1:0] s;
    c[0] = 1'b0;
    for (int i = 0; i < N; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[N], s};
  endfunction

  // One shift-add step: the adder carry becomes the new accumulator MSB.
  always_comb begin
    if (acc_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {N{1'b0}};
    end
    {carry_s, sum_s} = rca_add(acc_r[2*N-1:N], addend_s);
    acc_next_s       = {carry_s, sum_s, acc_r[N-1:1]};
    last_step_s      = (step_r == CW'(N - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (last_step_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Status outputs decoded from registered state only.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
        done = 1'b0;
      end
      CALC: begin
        busy = 1'b1;
        done = 1'b0;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture on accept, shift-add in CALC, product on last step.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mcand_r <= {N{1'b0}};
      acc_r   <= {(2*N){1'b0}};
      step_r  <= {CW{1'b0}};
      product <= {(2*N){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r <= a;
            acc_r   <= {{N{1'b0}}, b};
            step_r  <= {CW{1'b0}};
          end else begin
            mcand_r <= mcand_r;
            acc_r   <= acc_r;
            step_r  <= step_r;
          end
        end
        CALC: begin
          acc_r  <= acc_next_s;
          step_r <= step_r + CW'(1);
          if (last_step_s) begin
            product <= acc_next_s;
          end else begin
            product <= product;
          end
        end
        default: begin
          mcand_r <= mcand_r;
          acc_r   <= acc_r;
          step_r  <= step_r;
          product <= product;
        end
      endcase
    end
  end

endmodule
